// File: rtl/fifo_param_pkg.sv
// Shared constants, types and helpers for the parametrised FIFO.
package fifo_param_pkg;

    localparam int unsigned DefDataW    = 8;
    localparam int unsigned DefDepth    = 16;
    localparam int unsigned DefAfThresh = 14;
    localparam int unsigned DefAeThresh = 2;
    localparam int unsigned DefFwft     = 0;

    typedef enum logic {
        MODE_REG  = 1'b0,
        MODE_FWFT = 1'b1
    } read_mode_e;

    // Occupancy needs to represent 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic read_mode_e mode_of(input int unsigned fwft);
        return (fwft != 0) ? MODE_FWFT : MODE_REG;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array with one synchronous write port and one asynchronous read port.
module fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sva.sv
// Structural invariants of the FIFO status outputs.
module fifo_sva #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = 14,
    parameter int unsigned AE_THRESH = 2,
    parameter int unsigned CW        = 5
) (
    input logic          clk,
    input logic          rst,
    input logic [CW-1:0] i_count,
    input logic          i_empty,
    input logic          i_full,
    input logic          i_almost_full,
    input logic          i_almost_empty
);

    localparam logic [CW-1:0] CntMax = CW'(DEPTH);
    localparam logic [CW-1:0] AfTh   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AeTh   = CW'(AE_THRESH);

    a_count_bound: assert property (@(posedge clk) disable iff (rst) i_count <= CntMax);
    a_empty_full_excl: assert property (@(posedge clk) disable iff (rst) !(i_empty && i_full));
    a_empty_cnt: assert property (@(posedge clk) disable iff (rst) i_empty == (i_count == '0));
    a_full_cnt: assert property (@(posedge clk) disable iff (rst) i_full == (i_count == CntMax));
    a_af_cnt: assert property (@(posedge clk) disable iff (rst) i_almost_full == (i_count >= AfTh));
    a_ae_cnt: assert property (@(posedge clk) disable iff (rst) i_almost_empty == (i_count <= AeTh));

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with registered status, sticky error flags and
// selectable registered or first-word-fall-through read.
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned DEPTH     = DefDepth,
    parameter int unsigned AF_THRESH = DefAfThresh,
    parameter int unsigned AE_THRESH = DefAeThresh,
    parameter int unsigned FWFT      = DefFwft
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr,
    input  logic [DATA_W-1:0]         din,
    input  logic                      rd,
    output logic [DATA_W-1:0]         dout,
    output logic                      dout_valid,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clr_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] CntMax = CW'(DEPTH);
    localparam logic [CW-1:0] AfTh   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AeTh   = CW'(AE_THRESH);
    localparam read_mode_e Mode      = mode_of(FWFT);

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     w_count_d;
    logic              r_empty;
    logic              r_full;
    logic              r_almost_full;
    logic              r_almost_empty;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [DATA_W-1:0] w_rd_data;

    // Acceptance uses the registered flags, so a write while full is refused
    // even when a read frees a slot on the same edge.
    assign w_wr_acc = wr && !r_full;
    assign w_rd_acc = rd && !r_empty;

    always_comb begin
        w_count_d = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_d = r_count + 1'b1;
            2'b01:   w_count_d = r_count - 1'b1;
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count        <= w_count_d;
            r_empty        <= (w_count_d == '0);
            r_full         <= (w_count_d == CntMax);
            r_almost_full  <= (w_count_d >= AfTh);
            r_almost_empty <= (w_count_d <= AeTh);
            // A new error in the same cycle as clr_err keeps the flag set.
            r_overflow     <= (wr && r_full) || (r_overflow && !clr_err);
            r_underflow    <= (rd && r_empty) || (r_underflow && !clr_err);
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (din),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    if (Mode == MODE_FWFT) begin : g_fwft
        assign dout       = w_rd_data;
        assign dout_valid = !r_empty;
    end else begin : g_reg
        logic [DATA_W-1:0] r_dout;
        logic              r_dout_valid;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_dout       <= '0;
                r_dout_valid <= 1'b0;
            end else begin
                r_dout_valid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_dout <= w_rd_data;
                end
            end
        end

        assign dout       = r_dout;
        assign dout_valid = r_dout_valid;
    end

    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    fifo_sva #(
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH),
        .AE_THRESH (AE_THRESH),
        .CW        (CW)
    ) u_sva (
        .clk            (clk),
        .rst            (rst),
        .i_count        (r_count),
        .i_empty        (r_empty),
        .i_full         (r_full),
        .i_almost_full  (r_almost_full),
        .i_almost_empty (r_almost_empty)
    );

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: a registered-read instance and an FWFT instance.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       d_wr = 1'b0, d_rd = 1'b0, d_clr = 1'b0;
    logic [7:0] d_din = '0, d_dout;
    logic       d_dout_valid, d_empty, d_full, d_af, d_ae, d_ovf, d_udf;
    logic [4:0] d_count;

    logic       f_wr = 1'b0, f_rd = 1'b0, f_clr = 1'b0;
    logic [7:0] f_din = '0, f_dout;
    logic       f_dout_valid, f_empty, f_full, f_af, f_ae, f_ovf, f_udf;
    logic [4:0] f_count;

    int checks = 0;
    int failures = 0;

    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    fifo_param #(
        .DATA_W (8), .DEPTH (16), .AF_THRESH (14), .AE_THRESH (2), .FWFT (0)
    ) u_reg (
        .clk (clk), .rst (rst), .wr (d_wr), .din (d_din), .rd (d_rd),
        .dout (d_dout), .dout_valid (d_dout_valid), .empty (d_empty), .full (d_full),
        .almost_full (d_af), .almost_empty (d_ae), .count (d_count),
        .overflow (d_ovf), .underflow (d_udf), .clr_err (d_clr)
    );

    fifo_param #(
        .DATA_W (8), .DEPTH (16), .AF_THRESH (14), .AE_THRESH (2), .FWFT (1)
    ) u_fwft (
        .clk (clk), .rst (rst), .wr (f_wr), .din (f_din), .rd (f_rd),
        .dout (f_dout), .dout_valid (f_dout_valid), .empty (f_empty), .full (f_full),
        .almost_full (f_af), .almost_empty (f_ae), .count (f_count),
        .overflow (f_ovf), .underflow (f_udf), .clr_err (f_clr)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One cycle on the registered instance; the model decides acceptance from
    // pre-edge occupancy and queues the expected read data.
    task automatic d_op(input bit w, input bit r, input logic [7:0] data);
        bit rok, wok;
        d_wr  = w;
        d_rd  = r;
        d_din = data;
        rok = r && (model_q.size() != 0);
        wok = w && (model_q.size() < 16);
        if (rok) exp_q.push_back(model_q.pop_front());
        if (wok) model_q.push_back(data);
        cyc();
        d_wr = 1'b0;
        d_rd = 1'b0;
    endtask

    // Monitor: every dout_valid pulse must match the oldest expected word.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (d_dout_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual=%0h required=no_output", d_dout);
                end else begin
                    check("sb_dout", d_dout, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        cyc();
        cyc();
        rst = 1'b0;

        // 1: random traffic then a two-cycle reset
        for (int i = 0; i < 6; i++) d_op(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        d_op(1'b0, 1'b1, 8'h00);
        d_op(1'b0, 1'b1, 8'h00);
        d_op(1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        model_q.delete();
        check("rst_count", d_count, 0);
        check("rst_empty", d_empty, 1);
        check("rst_full", d_full, 0);
        check("rst_ae", d_ae, 1);
        check("rst_af", d_af, 0);
        check("rst_ovf", d_ovf, 0);
        check("rst_udf", d_udf, 0);
        check("rst_dvalid", d_dout_valid, 0);
        check("rst_dout", d_dout, 0);
        check("rst_fwft_valid", f_dout_valid, 0);

        // 2: fill to full, then one rejected write
        for (int i = 0; i < 16; i++) begin
            d_op(1'b1, 1'b0, 8'(i));
            check("fill_count", d_count, i + 1);
            check("fill_af", d_af, (i + 1) >= 14);
            check("fill_ae", d_ae, (i + 1) <= 2);
            check("fill_full", d_full, i == 15);
        end
        d_op(1'b1, 1'b0, 8'hAA);
        check("ovf_set", d_ovf, 1);
        check("ovf_count", d_count, 16);
        check("ovf_full", d_full, 1);

        // 3: drain back-to-back, then an underflowing read
        for (int i = 0; i < 16; i++) begin
            d_op(1'b0, 1'b1, 8'h00);
            check("drain_valid", d_dout_valid, 1);
        end
        check("drain_empty", d_empty, 1);
        check("drain_count", d_count, 0);
        d_op(1'b0, 1'b1, 8'h00);
        check("udf_set", d_udf, 1);
        check("udf_hold_dout", d_dout, 8'h0F);
        check("udf_no_valid", d_dout_valid, 0);

        // 6a: clr_err, and set-wins when an error coincides with clr_err
        d_clr = 1'b1;
        cyc();
        d_clr = 1'b0;
        check("clr_ovf", d_ovf, 0);
        check("clr_udf", d_udf, 0);
        d_clr = 1'b1;
        d_op(1'b0, 1'b1, 8'h00);
        d_clr = 1'b0;
        check("clr_setwins_udf", d_udf, 1);
        check("clr_setwins_ovf", d_ovf, 0);
        d_clr = 1'b1;
        cyc();
        d_clr = 1'b0;

        // 4: steady-state concurrent traffic across pointer wrap
        for (int i = 0; i < 5; i++) d_op(1'b1, 1'b0, 8'(16 + i));
        check("pre_count", d_count, 5);
        for (int i = 0; i < 40; i++) begin
            d_op(1'b1, 1'b1, 8'(21 + i));
            check("conc_count", d_count, 5);
        end
        for (int i = 0; i < 11; i++) d_op(1'b1, 1'b0, 8'(128 + i));
        check("refill_full", d_full, 1);
        d_op(1'b1, 1'b1, 8'hEE);
        check("full_rw_count", d_count, 15);
        check("full_rw_ovf", d_ovf, 1);
        check("full_rw_notfull", d_full, 0);
        for (int i = 0; i < 15; i++) d_op(1'b0, 1'b1, 8'h00);
        d_op(1'b0, 1'b0, 8'h00);
        check("wrap_empty", d_empty, 1);
        check("wrap_sb_drained", exp_q.size(), 0);
        d_clr = 1'b1;
        cyc();
        d_clr = 1'b0;

        // 6b: reset at count 9 with a read pending on the same edge
        for (int i = 0; i < 9; i++) d_op(1'b1, 1'b0, 8'(64 + i));
        check("pre_rst_count", d_count, 9);
        rst  = 1'b1;
        d_rd = 1'b1;
        cyc();
        rst  = 1'b0;
        d_rd = 1'b0;
        model_q.delete();
        check("midrst_count", d_count, 0);
        check("midrst_empty", d_empty, 1);
        check("midrst_dvalid", d_dout_valid, 0);
        check("midrst_ae", d_ae, 1);

        // 5: first-word-fall-through instance
        f_wr  = 1'b1;
        f_din = 8'h5A;
        cyc();
        f_wr = 1'b0;
        check("fwft_valid", f_dout_valid, 1);
        check("fwft_dout", f_dout, 8'h5A);
        check("fwft_count", f_count, 1);
        cyc();
        check("fwft_hold_valid", f_dout_valid, 1);
        check("fwft_hold_dout", f_dout, 8'h5A);
        f_rd = 1'b1;
        cyc();
        f_rd = 1'b0;
        check("fwft_pop_empty", f_empty, 1);
        check("fwft_pop_valid", f_dout_valid, 0);
        f_wr  = 1'b1;
        f_din = 8'hA1;
        cyc();
        f_din = 8'hA2;
        cyc();
        f_wr = 1'b0;
        check("fwft_head1", f_dout, 8'hA1);
        f_rd = 1'b1;
        cyc();
        check("fwft_head2", f_dout, 8'hA2);
        check("fwft_head2_valid", f_dout_valid, 1);
        cyc();
        check("fwft_drain_empty", f_empty, 1);
        cyc();
        f_rd = 1'b0;
        check("fwft_udf", f_udf, 1);

        cyc();
        check("sb_final_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
